// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM states
// and the alignment rule used to reject accesses before they reach the bus.
package lsu_pkg;

  localparam logic [1:0] LsuSizeB = 2'd0;
  localparam logic [1:0] LsuSizeH = 2'd1;
  localparam logic [1:0] LsuSizeW = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  // Size 3 is not a legal encoding and is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LsuSizeB: mis = 1'b0;
      LsuSizeH: mis = addr_lo[0];
      LsuSizeW: mis = |addr_lo;
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes and lane-replicated store data,
// plus load-data extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    load_o  = '0;
    case (size_i)
      LsuSizeB: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      LsuSizeH: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = {{16{~uns_i & half_sel[15]}}, half_sel};
      end
      LsuSizeW: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        load_o  = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: captures one EXU memory operation, runs a single data-bus
// transaction with a response timeout and returns a one-cycle completion pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        req_active;

  lsu_align u_align (
    .size_i    (size_q),
    .uns_i     (uns_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_resp_rdata),
    .wstrb_o   (align_wstrb),
    .wdata_o   (align_wdata),
    .load_o    (align_load)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = is_misaligned(req_size, req_addr[1:0]);
          state_d = err_d ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          rdata_d = store_q ? '0 : align_load;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          // WAIT has lasted TIMEOUT_CYCLES+1 cycles with no response.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      store_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus fields are decoded from state and capture registers only, so they stay
  // stable for the whole REQ phase and read as zero elsewhere.
  assign req_active    = (state_q == StReq);
  assign mem_req_valid = req_active;
  assign mem_req_wen   = req_active & store_q;
  assign mem_req_addr  = req_active ? {addr_q[31:2], 2'b00} : '0;
  assign mem_req_wdata = (req_active & store_q) ? align_wdata : '0;
  assign mem_req_wstrb = (req_active & store_q) ? align_wstrb : 4'b0000;

  assign resp_valid = (state_q == StDone);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomised and directed bench for lsu, checked against a byte-arithmetic
// reference model of the access rules.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_store      (req_store),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % m_bytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input bit st, input logic [1:0] sz,
                                         input logic [31:0] a);
    logic [3:0] m;
    int lane;
    int n;
    m = 4'b0000;
    if (!st) return m;
    lane = int'(a % 4);
    n = m_bytes(sz);
    for (int i = 0; i < 4; i++) if (i >= lane && i < lane + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit un,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    n = m_bytes(sz);
    off = (n == 4) ? 0 : int'(a % 4) - int'(a % 4) % n;
    mask = (n == 1) ? 32'h0000_00FF : (n == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    v = (rd >> (8 * off)) & mask;
    if (!un && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one request and follows it cycle by cycle; ready is granted after
  // rdy_dly stall cycles and the response comes rsp_dly cycles into WAIT.
  task automatic run_txn(input bit st, input logic [1:0] sz, input bit un,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_dly, input int rsp_dly, input string tag);
    logic [31:0] exp_r;
    bit exp_e;
    int exp_done;
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (m_misaligned(sz, a)) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 ||
          mem_req_valid !== 1'b0)
        begin errors++; $display("FAIL %s misaligned: valid=%0b err=%0b rdata=%h busreq=%0b, want 1 1 0 0",
                                 tag, resp_valid, resp_err, resp_rdata, mem_req_valid); end
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
        begin errors++; $display("FAIL %s misaligned_pulse: valid=%0b busreq=%0b, want 0 0",
                                 tag, resp_valid, mem_req_valid); end
      return;
    end
    for (int c = 0; c <= rdy_dly; c++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== {a[31:2], 2'b00} || mem_req_wen !== st ||
          mem_req_wstrb !== m_wstrb(st, sz, a) || (st && mem_req_wdata !== m_wdata(sz, wd)) ||
          resp_valid !== 1'b0)
        begin errors++; $display("FAIL %s req c%0d: v=%0b addr=%h wen=%0b strb=%b wd=%h rv=%0b, want 1 %h %0b %b %h 0",
                                 tag, c, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb,
                                 mem_req_wdata, resp_valid, {a[31:2], 2'b00}, st,
                                 m_wstrb(st, sz, a), m_wdata(sz, wd)); end
      mem_req_ready = (c == rdy_dly);
      @(negedge clock);
    end
    mem_req_ready = 1'b0;
    exp_e = (rsp_dly > int'(TO));
    exp_done = exp_e ? int'(TO) + 1 : rsp_dly + 1;
    exp_r = (exp_e || st) ? 32'd0 : m_load(sz, un, a, rd);
    for (int k = 0; k <= exp_done; k++) begin
      checks++;
      if (resp_valid !== (k == exp_done) || mem_req_valid !== 1'b0)
        begin errors++; $display("FAIL %s wait k%0d: resp_valid=%0b busreq=%0b, want %0b 0",
                                 tag, k, resp_valid, mem_req_valid, k == exp_done); end
      if (k == exp_done) begin
        checks++;
        if (resp_rdata !== exp_r || resp_err !== exp_e)
          begin errors++; $display("FAIL %s resp: rdata=%h err=%0b, want %h %0b",
                                   tag, resp_rdata, resp_err, exp_r, exp_e); end
      end
      mem_resp_valid = (k == rsp_dly);
      mem_resp_rdata = (k == rsp_dly) ? rd : $urandom;
      @(negedge clock);
    end
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== exp_r || resp_err !== exp_e)
      begin errors++; $display("FAIL %s hold: valid=%0b rdata=%h err=%0b, want 0 %h %0b",
                               tag, resp_valid, resp_rdata, resp_err, exp_r, exp_e); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_req_wen !== 1'b0 || mem_req_addr !== 32'd0 ||
        mem_req_wdata !== 32'd0 || mem_req_wstrb !== 4'd0)
      begin errors++; $display("FAIL reset_values: rv=%0b rd=%h re=%0b mv=%0b wen=%0b addr=%h wd=%h strb=%b, want all 0",
                               resp_valid, resp_rdata, resp_err, mem_req_valid, mem_req_wen,
                               mem_req_addr, mem_req_wdata, mem_req_wstrb); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_loads();
    run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0, "lw_min");
    checks++;
    if (resp_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL lw_value: rdata=%h want deadbeef", resp_rdata); end
    run_txn(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 1, "lb");
    checks++;
    if (resp_rdata !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb_value: rdata=%h want ffffff80", resp_rdata); end
    run_txn(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 1, 0, "lbu");
    checks++;
    if (resp_rdata !== 32'h0000_0080) begin errors++;
      $display("FAIL lbu_value: rdata=%h want 00000080", resp_rdata); end
    run_txn(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h80FF_0000, 0, 2, "lh");
    checks++;
    if (resp_rdata !== 32'hFFFF_80FF) begin errors++;
      $display("FAIL lh_value: rdata=%h want ffff80ff", resp_rdata); end
  endtask

  task automatic test_stores();
    run_txn(1'b1, 2'd0, 1'b0, 32'h2001, 32'h1234_5678, 32'hAAAA_5555, 0, 0, "sb");
    run_txn(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_5678, 32'hAAAA_5555, 0, 0, "sh");
    run_txn(1'b1, 2'd2, 1'b0, 32'h2004, 32'hCAFE_F00D, 32'h0, 0, 1, "sw");
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h0, 0, 0, "lw_mis");
    run_txn(1'b1, 2'd1, 1'b0, 32'h2003, 32'hFFFF, 32'h0, 0, 0, "sh_mis");
    run_txn(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h0, 0, 0, "size3");
  endtask

  task automatic test_stall_timeout();
    run_txn(1'b1, 2'd0, 1'b0, 32'h4002, 32'h0000_00A5, 32'h0, 5, 0, "stall5");
    // Response arrives on the DONE cycle after the timeout and must be dropped.
    run_txn(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h1111_2222, 0, int'(TO) + 1, "timeout");
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || resp_rdata !== 32'd0 ||
          resp_err !== 1'b1)
        begin errors++; $display("FAIL late_resp: rv=%0b mv=%0b rdata=%h err=%0b, want 0 0 0 1",
                                 resp_valid, mem_req_valid, resp_rdata, resp_err); end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b0, 2'd0, 1'b0, 32'h6001, 32'h0, 32'h0000_AB00, 0, 0, "pre_rst");
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h6000;
    @(negedge clock);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_req_wen !== 1'b0 || mem_req_addr !== 32'd0 ||
        mem_req_wdata !== 32'd0 || mem_req_wstrb !== 4'd0)
      begin errors++; $display("FAIL reset_mid: rv=%0b rd=%h re=%0b mv=%0b addr=%h, want all 0",
                               resp_valid, resp_rdata, resp_err, mem_req_valid, mem_req_addr); end
    @(negedge clock);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5A5A_5A5A;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin errors++; $display("FAIL idle_drop: rv=%0b mv=%0b, want 0 0", resp_valid,
                               mem_req_valid); end
    run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0BAD_F00D, 0, 0, "post_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit st;
      bit un;
      logic [1:0] sz;
      logic [31:0] a;
      st = 1'($urandom_range(1));
      un = 1'($urandom_range(1));
      sz = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      a = $urandom;
      if ($urandom_range(3) != 0 && sz != 2'd3) a = a & ~32'(m_bytes(sz) - 1);
      run_txn(st, sz, un, a, $urandom, $urandom, int'($urandom_range(3)),
              int'($urandom_range(6)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_stall_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
